rtc_date_writer: RTL and testbench

Downstream of the front-panel date editor. On a commit strobe it snapshots the edited BCD day/month/year, range-checks them, and writes them to the external RTC chip as three write cycles on a multiplexed address/data bus (address phase, then data phase, each framed by chip select). It reports busy, done and error to the top-level controller, which leaves edit mode on done.

---
 rtl/rtc_pkg.sv | 48 ++++
 rtl/rtc_date_check.sv | 36 +++
 rtl/rtc_date_writer.sv | 164 ++++++++++++++++
 tb/tb_rtc_date_writer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC date writer: FSM states, default RTC register
// addresses, BCD calendar constants and small BCD helpers.
package rtc_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CHECK,
        S_A_SET,
        S_A_STB,
        S_A_HLD,
        S_D_SET,
        S_D_STB,
        S_D_HLD,
        S_GAP,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [7:0] ADDR_DAY_DEF  = 8'h24;
    localparam logic [7:0] ADDR_MON_DEF  = 8'h25;
    localparam logic [7:0] ADDR_YEAR_DEF = 8'h26;

    localparam logic [7:0] MON_JAN = 8'h01;
    localparam logic [7:0] MON_FEB = 8'h02;
    localparam logic [7:0] MON_DEC = 8'h12;

    localparam logic [7:0] MONTHS_30 [4] = '{8'h04, 8'h06, 8'h09, 8'h11};

    localparam logic [7:0] MAXDAY_31       = 8'h31;
    localparam logic [7:0] MAXDAY_30       = 8'h30;
    localparam logic [7:0] MAXDAY_FEB_LEAP = 8'h29;
    localparam logic [7:0] MAXDAY_FEB      = 8'h28;

    function automatic logic bcd_ok(input logic [7:0] b);
        return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
    endfunction

    // Divisible-by-4 test done directly on the two BCD digits; 00 counts as leap.
    function automatic logic leap_year(input logic [7:0] y);
        logic [3:0] units;
        units = y[3:0];
        if (!y[4])
            return (units == 4'd0) || (units == 4'd4) || (units == 4'd8);
        else
            return (units == 4'd2) || (units == 4'd6);
    endfunction

endpackage

// File: rtl/rtc_date_check.sv
// Combinational BCD date validator: digit range, month 01-12 and day 01..maxday
// with leap-year February. Shared with the front-panel editor stage.
module rtc_date_check
    import rtc_pkg::*;
(
    input  logic [7:0] day,
    input  logic [7:0] mon,
    input  logic [7:0] year,
    output logic       valid
);

    logic       digits_ok;
    logic       mon_ok;
    logic       day_ok;
    logic       is_30;
    logic [7:0] maxday;

    // With all digits <= 9, BCD values order the same as plain binary.
    always_comb begin
        digits_ok = bcd_ok(day) && bcd_ok(mon) && bcd_ok(year);
        mon_ok    = (mon >= MON_JAN) && (mon <= MON_DEC);
        is_30     = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (mon == MONTHS_30[i]) is_30 = 1'b1;
        end
        if (mon == MON_FEB)
            maxday = leap_year(year) ? MAXDAY_FEB_LEAP : MAXDAY_FEB;
        else if (is_30)
            maxday = MAXDAY_30;
        else
            maxday = MAXDAY_31;
        day_ok = (day >= 8'h01) && (day <= maxday);
        valid  = digits_ok && mon_ok && day_ok;
    end

endmodule

// File: rtl/rtc_date_writer.sv
// Writes a committed BCD date to the external RTC as three muxed addr/data
// bus cycles. Define DATE_VALIDATE_EN to range-check the snapshot before writing.
module rtc_date_writer
    import rtc_pkg::*;
#(
    parameter int unsigned T_PH      = 4,
    parameter logic [7:0]  ADDR_DAY  = ADDR_DAY_DEF,
    parameter logic [7:0]  ADDR_MON  = ADDR_MON_DEF,
    parameter logic [7:0]  ADDR_YEAR = ADDR_YEAR_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       commit,
    input  logic [7:0] dia_c,
    input  logic [7:0] mes_c,
    input  logic [7:0] year_c,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       cs_n,
    output logic       wr_n,
    output logic       rd_n,
    output logic       a_d,
    output logic [7:0] ad_out,
    output logic       ad_oe
);

    localparam logic [3:0] PH_LAST = 4'(T_PH - 1);

    state_t     state, state_next;
    logic [1:0] reg_idx, reg_next;
    logic [3:0] cnt, cnt_next;
    logic [7:0] snap_day, snap_mon, snap_year;
    logic       date_ok;

    logic       busy_d, done_d, err_d, cs_n_d, wr_n_d, a_d_d, ad_oe_d;
    logic [7:0] ad_out_d, addr_sel, data_sel;

`ifdef DATE_VALIDATE_EN
    rtc_date_check u_date_check (
        .day   (snap_day),
        .mon   (snap_mon),
        .year  (snap_year),
        .valid (date_ok)
    );
`else
    assign date_ok = 1'b1;
`endif

    assign rd_n = 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            reg_idx <= 2'd0;
            cnt     <= 4'd0;
        end else begin
            state   <= state_next;
            reg_idx <= reg_next;
            cnt     <= cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_IDLE && commit) begin
            snap_day  <= dia_c;
            snap_mon  <= mes_c;
            snap_year <= year_c;
        end
    end

    always_comb begin
        state_next = state;
        reg_next   = reg_idx;
        cnt_next   = 4'd0;
        case (state)
            S_IDLE: begin
                reg_next = 2'd0;
                if (commit) state_next = S_CHECK;
            end
            S_CHECK: state_next = date_ok ? S_A_SET : S_ERR;
            S_A_SET, S_A_STB, S_A_HLD, S_D_SET, S_D_STB, S_D_HLD, S_GAP: begin
                if (cnt != PH_LAST) begin
                    cnt_next = cnt + 4'd1;
                end else begin
                    case (state)
                        S_A_SET: state_next = S_A_STB;
                        S_A_STB: state_next = S_A_HLD;
                        S_A_HLD: state_next = S_D_SET;
                        S_D_SET: state_next = S_D_STB;
                        S_D_STB: state_next = S_D_HLD;
                        S_D_HLD: state_next = S_GAP;
                        default: begin
                            if (reg_idx == 2'd2) begin
                                state_next = S_DONE;
                            end else begin
                                state_next = S_A_SET;
                                reg_next   = reg_idx + 2'd1;
                            end
                        end
                    endcase
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so the pins
    // change in the same cycle the state does.
    always_comb begin
        case (reg_next)
            2'd0:    begin addr_sel = ADDR_DAY;  data_sel = snap_day;  end
            2'd1:    begin addr_sel = ADDR_MON;  data_sel = snap_mon;  end
            default: begin addr_sel = ADDR_YEAR; data_sel = snap_year; end
        endcase
        busy_d   = !(state_next inside {S_IDLE, S_DONE, S_ERR});
        done_d   = (state_next == S_DONE);
        err_d    = (state_next == S_ERR);
        cs_n_d   = 1'b1;
        wr_n_d   = 1'b1;
        a_d_d    = 1'b1;
        ad_oe_d  = 1'b0;
        ad_out_d = 8'h00;
        case (state_next)
            S_A_SET, S_A_STB, S_A_HLD: begin
                cs_n_d   = 1'b0;
                ad_oe_d  = 1'b1;
                ad_out_d = addr_sel;
                wr_n_d   = (state_next != S_A_STB);
            end
            S_D_SET, S_D_STB, S_D_HLD: begin
                cs_n_d   = 1'b0;
                a_d_d    = 1'b0;
                ad_oe_d  = 1'b1;
                ad_out_d = data_sel;
                wr_n_d   = (state_next != S_D_STB);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            cs_n   <= 1'b1;
            wr_n   <= 1'b1;
            a_d    <= 1'b1;
            ad_out <= 8'h00;
            ad_oe  <= 1'b0;
        end else begin
            busy   <= busy_d;
            done   <= done_d;
            err    <= err_d;
            cs_n   <= cs_n_d;
            wr_n   <= wr_n_d;
            a_d    <= a_d_d;
            ad_out <= ad_out_d;
            ad_oe  <= ad_oe_d;
        end
    end

endmodule

// File: tb/tb_rtc_date_writer.sv
// Directed bench for rtc_date_writer: cycle-exact bus timing, validation
// outcomes, commit-while-busy and reset abort.
module tb_rtc_date_writer;

    localparam int T_PH = 4;
`ifdef DATE_VALIDATE_EN
    localparam bit VAL_EN = 1'b1;
`else
    localparam bit VAL_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       commit = 1'b0;
    logic [7:0] dia_c = 8'h00, mes_c = 8'h00, year_c = 8'h00;
    logic       busy, done, err, cs_n, wr_n, rd_n, a_d, ad_oe;
    logic [7:0] ad_out;

    int n_checks = 0;
    int n_pass   = 0;

    logic [8:0] exp_q[$];
    logic [8:0] got_q[$];
    logic       wr_prev = 1'b1;

    always #5 clk = ~clk;

    rtc_date_writer #(
        .T_PH      (T_PH),
        .ADDR_DAY  (8'h24),
        .ADDR_MON  (8'h25),
        .ADDR_YEAR (8'h26)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .commit (commit),
        .dia_c  (dia_c),
        .mes_c  (mes_c),
        .year_c (year_c),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .cs_n   (cs_n),
        .wr_n   (wr_n),
        .rd_n   (rd_n),
        .a_d    (a_d),
        .ad_out (ad_out),
        .ad_oe  (ad_oe)
    );

    // Bus monitor: record {a_d, ad_out} at every falling edge of wr_n.
    always @(negedge clk) begin
        if (!wr_n && wr_prev) got_q.push_back({a_d, ad_out});
        wr_prev = wr_n;
    end

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if ({busy, done, err} !== 3'b000) $display("FAIL reset_status got=%b want=000", {busy, done, err}); else n_pass++;
        n_checks++; if ({cs_n, wr_n, rd_n, a_d} !== 4'b1111) $display("FAIL reset_strobes got=%b want=1111", {cs_n, wr_n, rd_n, a_d}); else n_pass++;
        n_checks++; if (ad_out !== 8'h00) $display("FAIL reset_ad_out got=%h want=00", ad_out); else n_pass++;
        n_checks++; if (ad_oe !== 1'b0) $display("FAIL reset_ad_oe got=%b want=0", ad_oe); else n_pass++;
        reset = 1'b0;
        @(negedge clk);
        got_q.delete();
    endtask

    // Drives one commit and checks every cycle against the expected bus timeline.
    // poke_t > 0: at that cycle offset pulse commit again and scramble the inputs.
    task automatic run_commit(input logic [7:0] d, input logic [7:0] m, input logic [7:0] y,
                              input bit ok, input int poke_t, input string tag);
        logic [7:0] addr [3];
        logic [7:0] data [3];
        logic [7:0] e_vec, o_vec, e_ad, o_ad;
        int t_end, p, r, ph;
        addr = '{8'h24, 8'h25, 8'h26};
        data = '{d, m, y};
        exp_q.delete();
        got_q.delete();
        if (ok) begin
            for (int i = 0; i < 3; i++) begin
                exp_q.push_back({1'b1, addr[i]});
                exp_q.push_back({1'b0, data[i]});
            end
        end
        t_end = ok ? 2 + 21 * T_PH : 2;
        @(negedge clk);
        dia_c = d; mes_c = m; year_c = y; commit = 1'b1;
        for (int t = 1; t <= t_end + 3; t++) begin
            @(negedge clk);
            commit = 1'b0;
            // e_vec = {busy, done, err, cs_n, wr_n, rd_n, a_d, ad_oe}
            e_vec = 8'b000_11110;
            e_ad  = 8'h00;
            if (t == 1) begin
                e_vec[7] = 1'b1;
            end else if (ok && t < t_end) begin
                e_vec[7] = 1'b1;
                p  = (t - 2) / T_PH;
                r  = p / 7;
                ph = p % 7;
                if (ph != 6) begin
                    e_vec[4] = 1'b0;
                    e_vec[3] = (ph == 1 || ph == 4) ? 1'b0 : 1'b1;
                    e_vec[1] = (ph < 3);
                    e_vec[0] = 1'b1;
                    e_ad     = (ph < 3) ? addr[r] : data[r];
                end
            end else if (t == t_end) begin
                if (ok) e_vec[6] = 1'b1;
                else    e_vec[5] = 1'b1;
            end
            o_vec = {busy, done, err, cs_n, wr_n, rd_n, a_d, ad_oe};
            o_ad  = e_vec[0] ? ad_out : 8'h00;
            n_checks++;
            if ({o_vec, o_ad} !== {e_vec, e_ad})
                $display("FAIL %s t=%0d pins got=%b ad=%h want=%b ad=%h", tag, t, o_vec, o_ad, e_vec, e_ad);
            else n_pass++;
            if (t == poke_t) begin
                commit = 1'b1;
                dia_c = 8'h77; mes_c = 8'h66; year_c = 8'h55;
            end
        end
        n_checks++;
        if (got_q.size() !== exp_q.size())
            $display("FAIL %s sb_count got=%0d want=%0d", tag, got_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) $display("FAIL %s sb_item%0d got=%h want=%h", tag, i, got_q[i], exp_q[i]);
            else n_pass++;
        end
    endtask

    task automatic test_basic_write();
        run_commit(8'h15, 8'h08, 8'h23, 1'b1, 0, "write_150823");
    endtask

    task automatic test_leap_years();
        run_commit(8'h29, 8'h02, 8'h24, 1'b1, 0, "leap_290224");
        run_commit(8'h29, 8'h02, 8'h00, 1'b1, 0, "leap_290200");
        run_commit(8'h31, 8'h12, 8'h99, 1'b1, 0, "max_311299");
        run_commit(8'h29, 8'h02, 8'h23, !VAL_EN, 0, "noleap_290223");
    endtask

    task automatic test_invalid();
        run_commit(8'h31, 8'h04, 8'h22, !VAL_EN, 0, "bad_310422");
        run_commit(8'h00, 8'h05, 8'h22, !VAL_EN, 0, "bad_000522");
        run_commit(8'h12, 8'h13, 8'h22, !VAL_EN, 0, "bad_121322");
        run_commit(8'h1A, 8'h05, 8'h22, !VAL_EN, 0, "bad_1a0522");
    endtask

    task automatic test_back_to_back();
        // Poke lands in the month address phase.
        run_commit(8'h15, 8'h08, 8'h23, 1'b1, 2 + 7 * T_PH + 2, "busy_ignore");
        run_commit(8'h01, 8'h01, 8'h01, 1'b1, 0, "b2b_010101");
    endtask

    task automatic test_reset_abort();
        int done_seen;
        @(negedge clk);
        dia_c = 8'h15; mes_c = 8'h08; year_c = 8'h23; commit = 1'b1;
        // Month D_STB starts at offset 2 + 7*T_PH + 4*T_PH.
        for (int t = 1; t <= 2 + 11 * T_PH; t++) begin
            @(negedge clk);
            commit = 1'b0;
        end
        n_checks++;
        if ({wr_n, a_d, ad_out} !== {1'b0, 1'b0, 8'h08})
            $display("FAIL abort_in_dstb got=%b%b%h want=0008", wr_n, a_d, ad_out);
        else n_pass++;
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({cs_n, wr_n, ad_oe, busy, done} !== 5'b11000)
            $display("FAIL abort_idle got=%b want=11000", {cs_n, wr_n, ad_oe, busy, done});
        else n_pass++;
        reset = 1'b0;
        done_seen = 0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        n_checks++;
        if (done_seen !== 0) $display("FAIL abort_no_done got=%0d want=0", done_seen); else n_pass++;
        got_q.delete();
        run_commit(8'h07, 8'h11, 8'h30, 1'b1, 0, "after_abort");
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_leap_years();
        test_invalid();
        test_back_to_back();
        test_reset_abort();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
